pcihellocore_leds_out: RTL and testbench



---
 rtl/pcihellocore_pkg.sv | 15 +
 rtl/pcihellocore_blink_prescaler.sv | 45 ++++
 rtl/pcihellocore_leds_out.sv | 93 +++++++++
 tb/tb_pcihellocore_leds_out.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pcihellocore_pkg.sv
// Shared constants for the pcihellocore LED output port: register word
// addresses and the default prescaler width.
package pcihellocore_pkg;

    localparam int LEDS_ADDR_W = 3;
    localparam int LEDS_DIV_W  = 24;

    localparam logic [LEDS_ADDR_W-1:0] LEDS_ADDR_DATA       = 3'd0;
    localparam logic [LEDS_ADDR_W-1:0] LEDS_ADDR_BLINK_MASK = 3'd1;
    localparam logic [LEDS_ADDR_W-1:0] LEDS_ADDR_PRESCALE   = 3'd2;
    localparam logic [LEDS_ADDR_W-1:0] LEDS_ADDR_OUTSET     = 3'd3;
    localparam logic [LEDS_ADDR_W-1:0] LEDS_ADDR_OUTCLEAR   = 3'd4;
    localparam logic [LEDS_ADDR_W-1:0] LEDS_ADDR_STATUS     = 3'd5;

endpackage

// File: rtl/pcihellocore_blink_prescaler.sv
// Blink phase generator: the phase toggles every PRESCALE+1 cycles and is
// held at 0 while PRESCALE is 0 or while the PRESCALE register is written.
module pcihellocore_blink_prescaler
    import pcihellocore_pkg::*;
#(
    parameter int DIV_W = LEDS_DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] prescale,
    input  logic             clear,
    output logic             phase
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        cnt_d   = cnt_q + DIV_W'(1);
        phase_d = phase_q;
        // A PRESCALE write beats a coincident terminal count.
        if (clear || (prescale == '0)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == prescale) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignment so all flops update together.
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/pcihellocore_leds_out.sv
// Avalon-MM output port: DATA register with atomic set/clear, per-bit
// hardware blink, registered read data and registered output pins.
module pcihellocore_leds_out
    import pcihellocore_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                DIV_W       = LEDS_DIV_W,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LEDS_ADDR_W-1:0] address,
    input  logic                   chipselect,
    input  logic                   write_n,
    input  logic [DATA_W-1:0]      writedata,
    output logic [DATA_W-1:0]      readdata,
    output logic [DATA_W-1:0]      out_port
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [DIV_W-1:0]  prescale_q, prescale_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic [DATA_W-1:0] out_port_q, out_port_d;
    logic              wr_en;
    logic              prescale_wr;
    logic              phase;

    assign wr_en       = chipselect && !write_n;
    assign prescale_wr = wr_en && (address == LEDS_ADDR_PRESCALE);

    always_comb begin
        data_d     = data_q;
        mask_d     = mask_q;
        prescale_d = prescale_q;
        if (wr_en) begin
            case (address)
                LEDS_ADDR_DATA:       data_d     = writedata;
                LEDS_ADDR_BLINK_MASK: mask_d     = writedata;
                LEDS_ADDR_PRESCALE:   prescale_d = writedata[DIV_W-1:0];
                LEDS_ADDR_OUTSET:     data_d     = data_q | writedata;
                LEDS_ADDR_OUTCLEAR:   data_d     = data_q & ~writedata;
                default:              ;
            endcase
        end
    end

    // Read mux samples pre-edge register state every cycle, no read strobe.
    always_comb begin
        readdata_d = '0;
        case (address)
            LEDS_ADDR_DATA:       readdata_d = data_q;
            LEDS_ADDR_BLINK_MASK: readdata_d = mask_q;
            LEDS_ADDR_PRESCALE:   readdata_d = DATA_W'(prescale_q);
            LEDS_ADDR_STATUS:     readdata_d[0] = phase;
            default:              readdata_d = '0;
        endcase
    end

    always_comb begin
        out_port_d = data_q ^ (mask_q & {DATA_W{phase}});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            mask_q     <= '0;
            prescale_q <= '0;
            readdata_q <= '0;
            out_port_q <= RESET_VALUE;
        end else begin
            data_q     <= data_d;
            mask_q     <= mask_d;
            prescale_q <= prescale_d;
            readdata_q <= readdata_d;
            out_port_q <= out_port_d;
        end
    end

    pcihellocore_blink_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .prescale (prescale_q),
        .clear    (prescale_wr),
        .phase    (phase)
    );

    assign readdata = readdata_q;
    assign out_port = out_port_q;

endmodule

// File: tb/tb_pcihellocore_leds_out.sv
// Directed bench for pcihellocore_leds_out: expectations are queued before
// each clock edge and compared against readdata/out_port just after it.
module tb_pcihellocore_leds_out;

    localparam int          DATA_W = 32;
    localparam logic [31:0] RV     = 32'h0000_00A5;

    typedef enum logic {SRC_RD, SRC_OUT} src_e;
    typedef struct {
        string       tag;
        src_e        src;
        logic [31:0] exp;
    } sb_item_t;

    logic              clk;
    logic              reset;
    logic [2:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic [DATA_W-1:0] out_port;

    sb_item_t sb[$];
    int       n_vec;
    int       n_err;

    pcihellocore_leds_out #(
        .DATA_W      (DATA_W),
        .DIV_W       (24),
        .RESET_VALUE (RV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input src_e src, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.src = src;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic check();
        sb_item_t    it;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            it  = sb.pop_front();
            obs = (it.src == SRC_RD) ? readdata : out_port;
            n_vec++;
            assert (obs === it.exp) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic tick_check();
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic wr_start(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
    endtask

    task automatic idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic do_wr(input logic [2:0] a, input logic [31:0] d);
        wr_start(a, d);
        tick_check();
        idle();
    endtask

    task automatic do_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        push(tag, SRC_RD, exp);
        tick_check();
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = '0;

        // Reset state and first read of DATA after release
        tick_check();
        push("rst_out", SRC_OUT, RV);
        push("rst_rd", SRC_RD, 32'h0);
        tick_check();
        reset = 1'b0;
        push("rd_after_rst", SRC_RD, RV);
        push("out_after_rst", SRC_OUT, RV);
        tick_check();

        // DATA write: one extra cycle before out_port follows
        wr_start(3'd0, 32'h1234_5678);
        push("wr_out_old", SRC_OUT, RV);
        tick_check();
        idle();
        address = 3'd0;
        push("wr_out_new", SRC_OUT, 32'h1234_5678);
        push("wr_rd_data", SRC_RD, 32'h1234_5678);
        tick_check();

        // OUTSET / OUTCLEAR
        do_wr(3'd0, 32'h0000_00F0);
        do_wr(3'd3, 32'h0000_000F);
        do_wr(3'd4, 32'h0000_0030);
        do_rd("setclr_data", 3'd0, 32'h0000_00CF);
        push("setclr_out", SRC_OUT, 32'h0000_00CF);
        do_rd("rd_outset", 3'd3, 32'h0);
        do_rd("rd_outclear", 3'd4, 32'h0);

        // PRESCALE holds only DIV_W bits
        do_wr(3'd2, 32'hFFFF_FFFF);
        do_rd("pre_trunc", 3'd2, 32'h00FF_FFFF);

        // Blink with PRESCALE=3: four cycles per level
        do_wr(3'd0, 32'h0);
        do_wr(3'd1, 32'h1);
        do_wr(3'd2, 32'd3);
        address = 3'd5;
        for (int i = 0; i < 12; i++) begin
            logic [31:0] b;
            b = (i >= 4 && i < 8) ? 32'h1 : 32'h0;
            push($sformatf("blink_out_%0d", i), SRC_OUT, b);
            push($sformatf("blink_status_%0d", i), SRC_RD, b);
            tick_check();
        end

        // PRESCALE=0 written while phase is 1 stops the blink
        wr_start(3'd2, 32'h0);
        push("stop_out_hi", SRC_OUT, 32'h1);
        tick_check();
        idle();
        address = 3'd5;
        push("stop_out_lo", SRC_OUT, 32'h0);
        push("stop_status", SRC_RD, 32'h0);
        tick_check();
        for (int i = 0; i < 6; i++) begin
            push($sformatf("stopped_out_%0d", i), SRC_OUT, 32'h0);
            tick_check();
        end

        // PRESCALE write coinciding with terminal count: no toggle
        do_wr(3'd2, 32'd3);
        address = 3'd5;
        for (int i = 0; i < 3; i++) begin
            push($sformatf("tc_pre_%0d", i), SRC_RD, 32'h0);
            tick_check();
        end
        do_wr(3'd2, 32'd3);
        address = 3'd5;
        for (int i = 0; i < 4; i++) begin
            push($sformatf("tc_hold_%0d", i), SRC_RD, 32'h0);
            tick_check();
        end
        push("tc_toggle_status", SRC_RD, 32'h1);
        push("tc_toggle_out", SRC_OUT, 32'h1);
        tick_check();

        // Reset mid-blink (phase=1) with a simultaneous DATA write
        wr_start(3'd0, 32'hDEAD_BEEF);
        reset = 1'b1;
        push("midrst_out", SRC_OUT, RV);
        push("midrst_rd", SRC_RD, 32'h0);
        tick_check();
        reset = 1'b0;
        idle();
        address = 3'd5;
        push("postrst_out", SRC_OUT, RV);
        push("postrst_status", SRC_RD, 32'h0);
        tick_check();
        do_rd("postrst_mask", 3'd1, 32'h0);
        do_rd("postrst_pre", 3'd2, 32'h0);
        do_rd("postrst_data", 3'd0, RV);

        // Writes to STATUS and unused addresses change nothing
        do_wr(3'd5, 32'hFFFF_FFFF);
        do_wr(3'd6, 32'hFFFF_FFFF);
        do_wr(3'd7, 32'hFFFF_FFFF);
        do_rd("ign_data", 3'd0, RV);
        do_rd("ign_mask", 3'd1, 32'h0);
        do_rd("ign_pre", 3'd2, 32'h0);
        do_rd("ign_status", 3'd5, 32'h0);
        do_rd("rd_addr6", 3'd6, 32'h0);
        push("ign_out", SRC_OUT, RV);
        do_rd("rd_addr7", 3'd7, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
